// File: rtl/jt6295_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | jt6295_pkg                                                             |
// | Shared widths and arbiter FSM state encoding for the ROM port sharer.  |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
package jt6295_pkg;
    localparam int c_aw   = 18;
    localparam int c_dw   = 8;
    localparam int c_st_w = 2;

    localparam logic [c_st_w-1:0] c_st_idle   = 2'd0;
    localparam logic [c_st_w-1:0] c_st_settle = 2'd1;
    localparam logic [c_st_w-1:0] c_st_wait   = 2'd2;
endpackage
`default_nettype wire

// File: rtl/jt6295_rr_pick.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | jt6295_rr_pick                                                         |
// | Combinational round-robin picker with optional slot-0 fixed priority.  |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module jt6295_rr_pick
    import jt6295_pkg::*;
#(
    parameter int SLOTS = 2,
    parameter int PW    = $clog2(SLOTS)
)(
    input  logic [SLOTS-1:0] pend,
    input  logic [PW-1:0]    ptr,
    input  logic             prio,
    output logic [PW-1:0]    grant,
    output logic             any
);

    logic [SLOTS-1:0] w_rr_pend;
    logic [PW-1:0]    w_idx;

    always_comb begin
        grant     = '0;
        any       = 1'b0;
        w_idx     = '0;
        w_rr_pend = pend;
        if (prio) w_rr_pend[0] = 1'b0;
        if (prio && pend[0]) begin
            any = 1'b1;
        end else begin
            // Scan farthest-first so the slot nearest after ptr is written last.
            for (int k = SLOTS; k >= 1; k--) begin
                w_idx = PW'((int'(ptr) + k) % SLOTS);
                if (w_rr_pend[w_idx]) begin
                    grant = w_idx;
                    any   = 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/jt6295_rom_arb.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | jt6295_rom_arb                                                         |
// | Shares one ADPCM ROM port among SLOTS requesters with per-slot cache.  |
// | Define JT6295_ROM_ARB_PRIO_EN to give slot 0 fixed top priority.       |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module jt6295_rom_arb
    import jt6295_pkg::*;
#(
    parameter int SLOTS = 2,
    parameter int AW    = c_aw,
    parameter int DW    = c_dw
)(
    input  logic                clk,
    input  logic                rst,
    input  logic [SLOTS-1:0]    slot_cs,
    input  logic [SLOTS*AW-1:0] slot_addr,
    output logic [SLOTS*DW-1:0] slot_dout,
    output logic [SLOTS-1:0]    slot_ok,
    output logic                rom_cs,
    output logic [AW-1:0]       rom_addr,
    input  logic [DW-1:0]       rom_data,
    input  logic                rom_ok
);

    localparam int PW = $clog2(SLOTS);

`ifdef JT6295_ROM_ARB_PRIO_EN
    localparam logic c_prio = 1'b1;
`else
    localparam logic c_prio = 1'b0;
`endif

    logic [SLOTS-1:0]  r_valid;
    logic [SLOTS-1:0]  r_ok;
    logic [AW-1:0]     r_tag  [SLOTS];
    logic [DW-1:0]     r_data [SLOTS];
    logic [c_st_w-1:0] r_state;
    logic [c_st_w-1:0] w_state_nxt;
    logic [PW-1:0]     r_ptr;
    logic [PW-1:0]     r_g;
    logic [AW-1:0]     r_req_addr;
    logic [AW-1:0]     r_rom_addr;
    logic              r_rom_cs;

    logic [SLOTS-1:0]  w_hit;
    logic [SLOTS-1:0]  w_pend;
    logic [PW-1:0]     w_grant;
    logic [AW-1:0]     w_grant_addr;
    logic              w_any;
    logic              w_issue;
    logic              w_fill;

    generate
        for (genvar i = 0; i < SLOTS; i++) begin : g_slot
            assign w_hit[i]  = r_valid[i] & (r_tag[i] == slot_addr[i*AW +: AW]);
            assign w_pend[i] = slot_cs[i] & ~w_hit[i];
            assign slot_dout[i*DW +: DW] = r_data[i];
        end
    endgenerate

    jt6295_rr_pick #(
        .SLOTS (SLOTS),
        .PW    (PW)
    ) u_pick (
        .pend  (w_pend),
        .ptr   (r_ptr),
        .prio  (c_prio),
        .grant (w_grant),
        .any   (w_any)
    );

    assign w_grant_addr = slot_addr[w_grant*AW +: AW];
    assign slot_ok      = r_ok;
    assign rom_cs       = r_rom_cs;
    assign rom_addr     = r_rom_addr;

    always_ff @(posedge clk) begin
        if (rst) r_state <= c_st_idle;
        else     r_state <= w_state_nxt;
    end

    // SETTLE exists because rom_ok may still reflect the previous address.
    always_comb begin
        w_state_nxt = r_state;
        w_issue     = 1'b0;
        w_fill      = 1'b0;
        case (r_state)
            c_st_idle: begin
                if (w_any) begin
                    w_issue     = 1'b1;
                    w_state_nxt = c_st_settle;
                end
            end
            c_st_settle: w_state_nxt = c_st_wait;
            c_st_wait: begin
                if (rom_ok) begin
                    w_fill      = 1'b1;
                    w_state_nxt = c_st_idle;
                end
            end
            default: w_state_nxt = c_st_idle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid    <= '0;
            r_ok       <= '0;
            r_ptr      <= PW'(SLOTS-1);
            r_g        <= '0;
            r_req_addr <= '0;
            r_rom_addr <= '0;
            r_rom_cs   <= 1'b0;
            for (int i = 0; i < SLOTS; i++) begin
                r_tag[i]  <= '0;
                r_data[i] <= '0;
            end
        end else begin
            r_ok <= slot_cs & w_hit;
            if (w_issue) begin
                r_rom_cs   <= 1'b1;
                r_rom_addr <= w_grant_addr;
                r_req_addr <= w_grant_addr;
                r_g        <= w_grant;
                // In priority mode slot 0 does not consume a round-robin turn.
                if (!(c_prio && (w_grant == '0))) r_ptr <= w_grant;
            end
            if (w_fill) begin
                r_tag[r_g]   <= r_req_addr;
                r_data[r_g]  <= rom_data;
                r_valid[r_g] <= 1'b1;
                r_rom_cs     <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire
